vga_capture: RTL
================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line expected.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame expected.
REQ-003 piul1Clock  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-004 piul1Reset_n  in  1  asynchronous active-low reset.
REQ-005 piul1Enable  in  1  capture enable, sampled only at a frame boundary.
REQ-006 piul1HSync / piul1VSync  in  1 each  VGA syncs, active low.
REQ-007 piul1DataEn  in  1  high while the pixel is in the active region.
REQ-008 piul8Red / piul8Green / piul8Blue  in  8 each  pixel colour.
REQ-009 poul1WEnable  out  1  frame-buffer write strobe (320x240 write port).
REQ-010 poul17WAddr  out  17  frame-buffer write address, 0..76799.
REQ-011 poul12WData  out  12  RGB444 {R[7:4],G[7:4],B[7:4]}.
REQ-012 poul1FrameStart / poul1FrameDone  out  1 each  single-cycle pulses.
REQ-013 poul1Locked  out  1  last frame matched H_ACTIVE x V_ACTIVE.
REQ-014 poul1Overrun  out  1  sticky per frame; the current frame exceeded the active limits.
REQ-015 poul10LineLength / poul10LineCount  out  10 each  measured statistics (see Configuration).

Function
REQ-016 All inputs SHALL be registered once. Edge detection SHALL use the registered copy against its previous value.
REQ-017 The frame boundary SHALL be the falling edge of the registered VSync.
REQ-018 States: IDLE, ARMED, ACTIVE.
  - IDLE -> ARMED at a frame boundary with piul1Enable=1.
  - ARMED -> ACTIVE on the first registered DataEn=1.
  - ACTIVE -> ARMED at a boundary with Enable=1.
  - ARMED or ACTIVE -> IDLE at a boundary with Enable=0.
REQ-019 A pixel SHALL be kept iff x and y are both even, x<H_ACTIVE and y<V_ACTIVE, giving a 320x240 decimation.
  - x counts DataEn cycles within a line.
  - y counts completed active lines.
REQ-020 Write address SHALL be rowbase + (x>>1).
  - rowbase SHALL reset to 0 at each frame boundary.
  - rowbase SHALL increment by 320 at the end of each even line with y<V_ACTIVE.
  - No multiplier SHALL be used.
REQ-021 Latency: a pixel presented on the inputs at edge N SHALL produce poul1WEnable=1 with its address and data during cycle N+2.
REQ-022 End of line SHALL be the falling edge of registered DataEn in ACTIVE. At end of line: x SHALL clear and y SHALL increment, saturating at 1023.
REQ-023 A DataEn pixel with x>=H_ACTIVE, or a line with y>=V_ACTIVE, SHALL not be written and SHALL set poul1Overrun. poul17WAddr SHALL never exceed 76799.
REQ-024 poul1FrameStart SHALL pulse on the ARMED->ACTIVE transition.
REQ-025 poul1FrameDone SHALL pulse at a boundary that leaves ACTIVE. poul1Locked SHALL update on that same cycle.
  - Locked=1 iff y==V_ACTIVE and every line length was exactly H_ACTIVE.
  - Otherwise Locked=0.
REQ-026 A frame boundary coinciding with DataEn=1 SHALL take precedence: the pixel is discarded and counters restart.
REQ-027 poul1Overrun SHALL clear on poul1FrameStart.
REQ-028 In IDLE, poul1WEnable SHALL be 0 and the sync inputs SHALL be ignored except for boundary detection.

Reset
REQ-029 While piul1Reset_n=0, asynchronously:
  - state SHALL be IDLE;
  - all counters, rowbase and input registers SHALL be 0;
  - all outputs SHALL be 0, including Locked, Overrun and the statistics.
REQ-030 Reset mid-frame SHALL abandon the frame with no FrameDone. After release, capture SHALL resume only after the next frame boundary.

Configuration
REQ-031 With macro VGA_CAPTURE_STATS_EN defined:
  - poul10LineLength SHALL hold the length of the last completed line.
  - poul10LineCount SHALL hold y of the last completed frame, updated with FrameDone.
REQ-032 Without VGA_CAPTURE_STATS_EN:
  - both statistics outputs SHALL be tied to 0 and their registers omitted.
  - poul1Locked SHALL be unaffected.

Verification
REQ-033 Two standard 640x480@60 frames (800x525 timing), Enable=1, pixel value = x:
  - exactly 76800 writes per frame after the first boundary;
  - addresses 0..76799 in order;
  - Locked=1 after the second frame;
  - a pixel at (2,0) with R=G=B=0xAB SHALL write addr 1, data 0xAAA.
REQ-034 Line of 650 DataEn cycles in frame 2:
  - Overrun=1, no write beyond x=639;
  - Locked=0 at FrameDone;
  - LineLength=650 when STATS_EN is defined.
REQ-035 Enable dropped mid-frame: capture SHALL continue to the boundary; then FrameDone pulses, state goes to IDLE, and no further writes occur.
REQ-036 VSync falling edge on the same cycle as DataEn=1: that pixel is not written; FrameDone and the next FrameStart behave normally.
REQ-037 Reset asserted at line 100:
  - outputs SHALL be 0 immediately, with no FrameDone;
  - the first write after release SHALL occur only after a full boundary, at addr 0.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: decimates a VGA pixel stream 2:1 in both axes into a 320x240 RGB444
// frame-buffer write port. Optional line/frame statistics: define VGA_CAPTURE_STATS_EN.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset_n,
    input  logic        piul1Enable,
    input  logic        piul1HSync,
    input  logic        piul1VSync,
    input  logic        piul1DataEn,
    input  logic [7:0]  piul8Red,
    input  logic [7:0]  piul8Green,
    input  logic [7:0]  piul8Blue,
    output logic        poul1WEnable,
    output logic [16:0] poul17WAddr,
    output logic [11:0] poul12WData,
    output logic        poul1FrameStart,
    output logic        poul1FrameDone,
    output logic        poul1Locked,
    output logic        poul1Overrun,
    output logic [9:0]  poul10LineLength,
    output logic [9:0]  poul10LineCount
);
    localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
    localparam logic [16:0] ROW_STEP = 17'd320;
    localparam logic [16:0] ADDR_LIM = 17'd76800;

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} stateT;
    stateT state, stateNext;

    logic       enP0, hsP0, vsP0, vsPrevP0, deP0, dePrevP0;
    logic [7:0] redP0, greenP0, blueP0;
    logic       unusedBits;

    logic [9:0]  xCnt, yCnt;
    logic [16:0] rowBase, pixAddr;
    logic        lenBad;
    logic        boundary, startEv, doneEv, pixEv, eolEv, pixKeep, pixOver;

    function automatic logic [9:0] satInc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // stage p0: input registers and edge history
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            enP0     <= 1'b0;
            hsP0     <= 1'b0;
            vsP0     <= 1'b0;
            vsPrevP0 <= 1'b0;
            deP0     <= 1'b0;
            dePrevP0 <= 1'b0;
            redP0    <= 8'd0;
            greenP0  <= 8'd0;
            blueP0   <= 8'd0;
        end else begin
            enP0     <= piul1Enable;
            hsP0     <= piul1HSync;
            vsP0     <= piul1VSync;
            vsPrevP0 <= vsP0;
            deP0     <= piul1DataEn;
            dePrevP0 <= deP0;
            redP0    <= piul8Red;
            greenP0  <= piul8Green;
            blueP0   <= piul8Blue;
        end
    end

    // Horizontal sync and the colour low nibbles carry nothing the buffer needs.
    assign unusedBits = ^{hsP0, redP0[3:0], greenP0[3:0], blueP0[3:0]};

    assign boundary = vsPrevP0 & ~vsP0;

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) state <= IDLE;
        else               state <= stateNext;
    end

    // A boundary wins over any pixel or end-of-line seen on the same cycle.
    always_comb begin
        stateNext = state;
        startEv   = 1'b0;
        doneEv    = 1'b0;
        pixEv     = 1'b0;
        eolEv     = 1'b0;
        case (state)
            IDLE: begin
                if (boundary && enP0) stateNext = ARMED;
            end
            ARMED: begin
                if (boundary) begin
                    stateNext = enP0 ? ARMED : IDLE;
                end else if (deP0) begin
                    stateNext = ACTIVE;
                    startEv   = 1'b1;
                    pixEv     = 1'b1;
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    stateNext = enP0 ? ARMED : IDLE;
                    doneEv    = 1'b1;
                end else if (deP0) begin
                    pixEv = 1'b1;
                end else if (dePrevP0) begin
                    eolEv = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign pixAddr = rowBase + {8'd0, xCnt[9:1]};
    assign pixKeep = pixEv && !xCnt[0] && !yCnt[0] && (xCnt < H_LIM) && (yCnt < V_LIM)
                     && (pixAddr < ADDR_LIM);
    assign pixOver = pixEv && ((xCnt >= H_LIM) || (yCnt >= V_LIM));

    // Row base advances only after even lines, so odd lines never need it.
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            xCnt    <= 10'd0;
            yCnt    <= 10'd0;
            rowBase <= 17'd0;
            lenBad  <= 1'b0;
        end else if (boundary) begin
            xCnt    <= 10'd0;
            yCnt    <= 10'd0;
            rowBase <= 17'd0;
            lenBad  <= 1'b0;
        end else if (pixEv) begin
            xCnt <= satInc(xCnt);
        end else if (eolEv) begin
            xCnt <= 10'd0;
            yCnt <= satInc(yCnt);
            if (xCnt != H_LIM) lenBad <= 1'b1;
            if (!yCnt[0] && (yCnt < V_LIM)) rowBase <= rowBase + ROW_STEP;
        end
    end

    // stage p1: write port and status outputs
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            poul1WEnable    <= 1'b0;
            poul17WAddr     <= 17'd0;
            poul12WData     <= 12'd0;
            poul1FrameStart <= 1'b0;
            poul1FrameDone  <= 1'b0;
            poul1Locked     <= 1'b0;
            poul1Overrun    <= 1'b0;
        end else begin
            poul1WEnable    <= pixKeep;
            poul1FrameStart <= startEv;
            poul1FrameDone  <= doneEv;
            if (pixKeep) begin
                poul17WAddr <= pixAddr;
                poul12WData <= {redP0[7:4], greenP0[7:4], blueP0[7:4]};
            end
            if (doneEv) poul1Locked <= (yCnt == V_LIM) && !lenBad;
            if (startEv)      poul1Overrun <= 1'b0;
            else if (pixOver) poul1Overrun <= 1'b1;
        end
    end

`ifdef VGA_CAPTURE_STATS_EN
    logic [9:0] lineLenQ, lineCntQ;

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            lineLenQ <= 10'd0;
            lineCntQ <= 10'd0;
        end else begin
            if (eolEv)  lineLenQ <= xCnt;
            if (doneEv) lineCntQ <= yCnt;
        end
    end

    assign poul10LineLength = lineLenQ;
    assign poul10LineCount  = lineCntQ;
`else
    assign poul10LineLength = 10'd0;
    assign poul10LineCount  = 10'd0;
`endif

endmodule
